// File: rtl/spi_sram_master_pkg.sv
// Shared definitions for the SPI SRAM host controller.
// Provides the 23LC-style command bytes, the byte-address width and the
// controller state encoding used by the top-level FSM.
package spi_sram_pkg;

  localparam int         ADDR_W    = 24;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WAIT,
    DATA,
    GAP
  } state_t;

endpackage

// File: rtl/spi_sram_master_if.sv
// Memory-bus side of the SPI SRAM controller.
//   req_valid/req_ready : request handshake (accepted when both are high)
//   req_wr              : 1 = write, 0 = read
//   req_addr            : byte address
//   req_wdata           : write data
//   rsp_valid           : one-cycle pulse per completed byte
//   rsp_rdata           : last read byte, held between pulses
// master = CPU side issuing requests, slave = the controller.
interface spi_sram_master_if;
  import spi_sram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/spi_sram_shifter.sv
// 32-bit MSB-first load/shift register with a 6-bit bit counter.
//   load_word : load command+address word, 32 bits to go
//   load_byte : load a data byte into the top byte, 8 bits to go
//   shift_en  : shift left by one, sin enters at bit 0
//   sout      : serial output (bit 31)
//   bit_cnt   : bits remaining including the one currently on sout
//   done      : the bit currently on sout is the last one
//   rx_byte   : byte that will be held after this cycle's sample of sin
// Loads take priority over a shift in the same cycle.
module spi_sram_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_word,
  input  logic        load_byte,
  input  logic        shift_en,
  input  logic [31:0] word_in,
  input  logic [7:0]  byte_in,
  input  logic        sin,
  output logic        sout,
  output logic [5:0]  bit_cnt,
  output logic        done,
  output logic [7:0]  rx_byte
);

  logic [31:0] sh_q, sh_d;
  logic [5:0]  cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_word) begin
      sh_d  = word_in;
      cnt_d = 6'd32;
    end else if (load_byte) begin
      sh_d  = {byte_in, 24'h000000};
      cnt_d = 6'd8;
    end else if (shift_en) begin
      sh_d  = {sh_q[30:0], sin};
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Shift data needs no reset: it is always loaded before it is used.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign sout    = sh_q[31];
  assign bit_cnt = cnt_q;
  assign done    = (cnt_q == 6'd1);
  assign rx_byte = {sh_q[6:0], sin};

endmodule

// File: rtl/spi_sram_master.sv
// Host-side SPI SRAM controller (23LC-style serial SRAM).
// Turns single-byte read/write requests into command + 24-bit address +
// data transactions, streaming same-direction sequential accesses inside
// one chip-select window. The SPI bit clock is clk itself.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : request/response bus (slave modport)
//   cs_n, mosi : SPI chip select and serial out, change on rising clk
//   miso       : SPI serial in, sampled on rising clk
//   busy       : high while cs_n is low or during the CS gap
module spi_sram_master
  import spi_sram_pkg::*;
#(
  parameter int MISO_DELAY = 1,
  parameter int CS_GAP     = 1,
  parameter int BURST_EN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_sram_master_if.slave bus,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso,
  output logic             busy
);

  localparam logic [3:0] WAIT_INIT = 4'(MISO_DELAY - 1);
  localparam logic [3:0] GAP_INIT  = 4'(CS_GAP - 1);
  // Bits remaining when the last command bit is on mosi.
  localparam logic [5:0] CMD_LAST  = 6'd25;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              idle_rdy_q, idle_rdy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;

  logic              load_word, load_byte, shift_en;
  logic [7:0]        load_data;
  logic              sh_out, sh_done;
  logic [5:0]        bit_cnt;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_inc;
  logic              cont_ok, accept;

  spi_sram_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_word (load_word),
    .load_byte (load_byte),
    .shift_en  (shift_en),
    .word_in   ({bus.req_wr ? CMD_WRITE : CMD_READ, bus.req_addr}),
    .byte_in   (load_data),
    .sin       (miso),
    .sout      (sh_out),
    .bit_cnt   (bit_cnt),
    .done      (sh_done),
    .rx_byte   (rx_byte)
  );

  // Continuation: on the last data bit, a same-direction request for the
  // next address (24-bit wrap) is taken without reopening the window.
  assign addr_inc = addr_q + 24'd1;
  assign cont_ok  = (BURST_EN != 0) && (state_q == DATA) && sh_done &&
                    bus.req_valid && (bus.req_wr == wr_q) &&
                    (bus.req_addr == addr_inc);

  // idle_rdy_q keeps ready low in the first IDLE cycle after reset release.
  assign bus.req_ready = (idle_rdy_q && (state_q == IDLE)) || cont_ok;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    load_word   = 1'b0;
    load_byte   = 1'b0;
    load_data   = wdata_q;
    shift_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CMD;
          wr_d      = bus.req_wr;
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          load_word = 1'b1;
        end
      end
      CMD: begin
        shift_en = 1'b1;
        if (bit_cnt == CMD_LAST) state_d = ADDR;
      end
      ADDR: begin
        shift_en = 1'b1;
        if (sh_done) begin
          if (!wr_q && (MISO_DELAY > 0)) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d   = DATA;
            load_byte = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = DATA;
          load_byte = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (sh_done) begin
          rsp_valid_d = 1'b1;
          if (!wr_q) rsp_rdata_d = rx_byte;
          if (accept) begin
            addr_d    = bus.req_addr;
            wdata_d   = bus.req_wdata;
            load_data = bus.req_wdata;
            load_byte = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_INIT;
          end
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    idle_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      idle_rdy_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      idle_rdy_q  <= idle_rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Outputs decode straight from reset flops so reset forces them at once.
  assign cs_n = !(state_q inside {CMD, ADDR, WAIT, DATA});
  assign mosi = ((state_q == CMD) || (state_q == ADDR) ||
                 ((state_q == DATA) && wr_q)) && sh_out;
  assign busy = (state_q != IDLE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_sram_master.sv
// Bench for spi_sram_master: directed requests, a behavioural 23LC-style
// SRAM slave, and queue-based scoreboards for responses and cs_n windows.
module tb_spi_sram_master;

  localparam int MISO_DELAY = 1;
  localparam int CS_GAP     = 1;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } rsp_exp_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          len;
  } win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic miso  = 1'b0;
  logic cs_n, mosi, busy;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int last_rsp_cyc = 0;

  rsp_exp_t rsp_q[$];
  win_t     win_q[$];
  logic [7:0] mem [logic [23:0]];

  spi_sram_master_if bus ();

  spi_sram_master #(
    .MISO_DELAY (MISO_DELAY),
    .CS_GAP     (CS_GAP),
    .BURST_EN   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .cs_n  (cs_n),
    .mosi  (mosi),
    .miso  (miso),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred at cycle %0d, expected none", name, cyc);
  endtask

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // ---------------- SRAM slave model (samples/drives mid-cycle) ----------------
  int          s_cnt = 0;
  int          s_hi  = 0;
  int          s_j;
  logic        s_seen = 1'b0;
  logic [7:0]  s_cmd, s_wbyte, s_byte;
  logic [23:0] s_addr, s_ptr;
  win_t        s_w;

  always @(negedge clk) begin
    if (!cs_n) begin
      if (s_cnt == 0) begin
        if (s_seen) begin
          vectors++;
          if (s_hi < CS_GAP) begin
            miscompares++;
            $display("FAIL cs_gap: got %0d high cycles, expected at least %0d", s_hi, CS_GAP);
          end
        end
        s_cmd  = 8'h00;
        s_addr = 24'h000000;
      end
      s_cnt++;
      if (s_cnt <= 8) begin
        s_cmd = {s_cmd[6:0], mosi};
      end else if (s_cnt <= 32) begin
        s_addr = {s_addr[22:0], mosi};
        if (s_cnt == 32) s_ptr = s_addr;
      end else if (s_cmd == 8'h02) begin
        s_wbyte = {s_wbyte[6:0], mosi};
        if (((s_cnt - 32) % 8) == 0) begin
          mem[s_ptr] = s_wbyte;
          s_ptr      = s_ptr + 24'd1;
        end
      end
      miso = 1'b0;
      if (s_cmd == 8'h03 && s_cnt > 32) begin
        s_j = s_cnt - 33 - MISO_DELAY;
        if (s_j >= 0) begin
          s_byte = mem_rd(s_addr + 24'(s_j / 8));
          miso   = s_byte[7 - (s_j % 8)];
        end
      end
    end else begin
      if (s_cnt != 0) begin
        if (win_q.size() == 0) begin
          fail_event("win_unexpected");
        end else begin
          s_w = win_q.pop_front();
          check("win_cmd", 32'(s_cmd), 32'(s_w.cmd));
          check("win_addr", 32'(s_addr), 32'(s_w.addr));
          check("win_len", s_cnt, s_w.len);
        end
        s_cnt  = 0;
        s_hi   = 0;
        s_seen = 1'b1;
      end
      s_hi++;
      miso = 1'b0;
    end
  end

  // ---------------- response monitor ----------------
  rsp_exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail_event("rsp_unexpected");
      end else begin
        m_e = rsp_q.pop_front();
        check("rsp_cycle", cyc, m_e.cyc);
        if (m_e.rd) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_e.data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_win(input logic [7:0] cmd, input logic [23:0] a, input int len);
    win_t w;
    w.cmd = cmd; w.addr = a; w.len = len;
    win_q.push_back(w);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  // with req_valid still high so a burst can follow without a gap.
  task automatic issue(input logic wr, input logic [23:0] a, input logic [7:0] wd,
                       input logic cont, input logic want_rsp, input logic [7:0] rd_exp);
    int n = 0;
    rsp_exp_t e;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    #1;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      fail_event("accept_timeout");
    end else if (want_rsp) begin
      e.rd   = !wr;
      e.data = rd_exp;
      e.cyc  = cont ? last_rsp_cyc + 8 : cyc + (wr ? 41 : 41 + MISO_DELAY);
      last_rsp_cyc = e.cyc;
      rsp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || rsp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_event("done_timeout");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 24'h0;
    bus.req_wdata = 8'h0;
    mem[24'h000200] = 8'hA5;
    mem[24'h000400] = 8'h11;
    mem[24'h000401] = 8'h22;
    mem[24'h000402] = 8'h33;
    mem[24'h000403] = 8'h44;
    mem[24'h000010] = 8'h5A;
    mem[24'h000020] = 8'hC3;

    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    #1 check("ready_at_release", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("ready_after_release", 32'(bus.req_ready), 1);

    // single read
    push_win(8'h03, 24'h000200, 41);
    issue(1'b0, 24'h000200, 8'h00, 1'b0, 1'b1, 8'hA5);
    idle();
    wait_done();

    // write then read back the same byte
    push_win(8'h02, 24'h00FFFC, 40);
    push_win(8'h03, 24'h00FFFC, 41);
    issue(1'b1, 24'h00FFFC, 8'h3C, 1'b0, 1'b1, 8'h00);
    issue(1'b0, 24'h00FFFC, 8'h00, 1'b0, 1'b1, 8'h3C);
    idle();
    wait_done();
    check("mem_fffc", 32'(mem_rd(24'h00FFFC)), 32'h3C);

    // 4-byte burst read in one window
    push_win(8'h03, 24'h000400, 65);
    issue(1'b0, 24'h000400, 8'h00, 1'b0, 1'b1, 8'h11);
    issue(1'b0, 24'h000401, 8'h00, 1'b1, 1'b1, 8'h22);
    issue(1'b0, 24'h000402, 8'h00, 1'b1, 1'b1, 8'h33);
    issue(1'b0, 24'h000403, 8'h00, 1'b1, 1'b1, 8'h44);
    idle();
    wait_done();

    // burst write wrapping the address space
    push_win(8'h02, 24'hFFFFFF, 48);
    issue(1'b1, 24'hFFFFFF, 8'hAA, 1'b0, 1'b1, 8'h00);
    issue(1'b1, 24'h000000, 8'h55, 1'b1, 1'b1, 8'h00);
    idle();
    wait_done();
    check("mem_ffffff", 32'(mem_rd(24'hFFFFFF)), 32'hAA);
    check("mem_000000", 32'(mem_rd(24'h000000)), 32'h55);
    check("rdata_hold", 32'(bus.rsp_rdata), 32'h44);

    // non-sequential and direction-changing requests
    push_win(8'h03, 24'h000010, 41);
    push_win(8'h03, 24'h000020, 41);
    push_win(8'h02, 24'h000021, 40);
    issue(1'b0, 24'h000010, 8'h00, 1'b0, 1'b1, 8'h5A);
    issue(1'b0, 24'h000020, 8'h00, 1'b0, 1'b1, 8'hC3);
    issue(1'b1, 24'h000021, 8'h77, 1'b0, 1'b1, 8'h00);
    idle();
    wait_done();
    check("mem_000021", 32'(mem_rd(24'h000021)), 32'h77);

    // reset during address bit 12 of a read
    push_win(8'h03, 24'h0005A5, 20);
    issue(1'b0, 24'h5A5300, 8'h00, 1'b0, 1'b0, 8'h00);
    idle();
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n), 1);
    check("abort_mosi", 32'(mosi), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(bus.req_ready), 0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    check("abort_rdata", 32'(bus.rsp_rdata), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_at_rerelease", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("ready_after_rerelease", 32'(bus.req_ready), 1);
    push_win(8'h03, 24'h000200, 41);
    issue(1'b0, 24'h000200, 8'h00, 1'b0, 1'b1, 8'hA5);
    idle();
    wait_done();

    repeat (4) @(negedge clk);
    check("rsp_queue_empty", 32'(rsp_q.size()), 0);
    check("win_queue_empty", 32'(win_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_sram_master.md
Name: spi_sram_master

Overview:
- Host-side SPI SRAM controller between the 6502 core's memory bus and the external serial SRAM (23LC-style protocol).
- Converts single-byte read/write requests into SPI transactions: command, 24-bit address, then data.
- Streams sequential same-direction accesses within one chip-select window.
- SPI bit clock is the system clock: mosi and cs_n change on rising clk, and miso is sampled on rising clk.

Parameters:
- MISO_DELAY, 1: clk cycles between the last address bit on mosi and the first data bit on miso (read only, 0..7).
- CS_GAP, 1: minimum clk cycles cs_n stays high between transactions (1..15).
- BURST_EN, 1: when 1, sequential-address continuation is allowed; when 0, every request is a full transaction.

Ports:
- clk, input, 1: system clock; the only clock domain, shared with the SPI bit clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: controller accepts the request this cycle.
- req_wr, input, 1: 1 = write, 0 = read.
- req_addr, input, 24: byte address.
- req_wdata, input, 8: write data.
- rsp_valid, output, 1: one-cycle pulse when read data is valid or a write has completed.
- rsp_rdata, output, 8: read data; holds its value until the next rsp_valid.
- cs_n, output, 1: SPI chip select, active low.
- mosi, output, 1: serial data out, MSB first.
- miso, input, 1: serial data in, MSB first.
- busy, output, 1: high while cs_n is low or during the CS gap.

Behaviour:
- Reset values: cs_n=1, mosi=0, req_ready=0, rsp_valid=0, rsp_rdata=8'h00, busy=0, state=IDLE.
- Asserting rst_n low mid-transaction forces these values immediately. The aborted request gets no rsp_valid.
- States and transitions:
  - IDLE: req_ready=1 (registered; first asserts the cycle after reset release). On accept, capture wr/addr/wdata and go to CMD.
  - CMD: cs_n=0. Shift out 8 bits of 8'h03 (read) or 8'h02 (write). Go to ADDR.
  - ADDR: shift out 24 address bits. Write goes to DATA. Read goes to WAIT if MISO_DELAY>0, else DATA.
  - WAIT: MISO_DELAY cycles with mosi=0. Go to DATA.
  - DATA: 8 cycles. Write shifts out wdata; read samples miso into the shifter with mosi=0.
  - GAP: cs_n=1 for CS_GAP cycles, then IDLE.
- End of DATA (last bit cycle):
  - Continuation check: req_ready=1 combinationally iff BURST_EN, req_valid, req_wr equals the current direction, and req_addr equals current addr+1 (24-bit wrap: 24'hFFFFFF+1 = 24'h000000).
  - If accepted: stay in DATA for the next byte with cs_n held low. No command/address cycles and no bubble.
  - Otherwise: go to GAP.
- rsp_valid pulses the cycle after the last data bit. For reads, rsp_rdata updates in the same cycle.
- Latency from accept to rsp_valid:
  - single read: 8+24+MISO_DELAY+8+1 = 42 cycles at default.
  - single write: 41 cycles.
  - each burst continuation: 8 cycles.
- cs_n is low from the first CMD bit through the last DATA bit, inclusive.
- req_* inputs are ignored when req_ready=0, and are sampled only on the accept cycle.
- Request arriving during GAP: waits. It is accepted in the first IDLE cycle.
- Read followed by a write at addr+1 (direction change): not continued; full new transaction.

Decomposition:
- Package spi_sram_pkg:
  - CMD_READ=8'h03, CMD_WRITE=8'h02, ADDR_W=24.
  - state_t enum {IDLE, CMD, ADDR, WAIT, DATA, GAP}.
- Sub-module spi_sram_shifter:
  - 32-bit load/shift register with 6-bit bit counter.
  - Load ports: cmd+addr word, data byte.
  - Output: serial out; serial-in capture for read data.
  - done flag on final bit.
- Top level holds the FSM, the continuation comparator, and the gap counter.

Test Plan:
- Read addr 24'h000200 with slave memory [0x200]=8'hA5 -> mosi carries 0x03 then 0x000200; cs_n low 41 cycles; rsp_valid at accept+42; rsp_rdata=8'hA5.
- Write 8'h3C to 24'h00FFFC, then read it back -> slave mem[0xFFFC]=8'h3C; read returns 8'h3C; cs_n high ≥ CS_GAP cycles between the two transactions.
- Burst read of 4 bytes from 24'h000400 (mem 11,22,33,44), req_valid held with incrementing address -> a single cs_n window of 32+1+32 cycles; rsp_valid pulses spaced 8 cycles apart; data 11,22,33,44.
- Burst write at 24'hFFFFFF then 24'h000000 -> continued in one window (wrap); both bytes land at the correct addresses.
- Non-sequential or direction-changing request (read 0x10, then read 0x20, then write 0x21) -> three separate cs_n windows, each starting with its full command and address.
- Reset asserted at bit 12 of ADDR -> cs_n=1 and mosi=0 in the same cycle; no rsp_valid; after release req_ready=1 next cycle; a new read of 0x200 completes correctly.
